// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: FSM encoding, line geometry
// and the default memory latency.
package instr_fetch_unit_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam int LINE_BYTES       = 16;
  localparam int WORD_SEL_LSB     = 2;
  localparam int WORD_SEL_MSB     = 3;
  localparam int TAG_LSB          = 4;
  localparam int DEFAULT_MEM_WAIT = 8;

  typedef logic [WORD_SEL_MSB-WORD_SEL_LSB:0] word_sel_t;

endpackage

// File: rtl/instr_fetch_unit_line_word_sel.sv
// Combinational 128->32 word picker; word 0 sits in the most significant
// slice so byte offsets increase toward the LSBs.
module line_word_sel
  import instr_fetch_unit_pkg::*;
(
  input  logic [127:0] line_i,
  input  word_sel_t    sel_i,
  output logic [31:0]  word_o
);

  always_comb begin
    word_o = line_i[127:96];
    case (sel_i)
      2'd0:    word_o = line_i[127:96];
      2'd1:    word_o = line_i[95:64];
      2'd2:    word_o = line_i[63:32];
      default: word_o = line_i[31:0];
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch requester: one-entry line buffer in front of a fixed
// latency 128-bit instruction memory, with flush-driven redirects.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int MEM_WAIT = DEFAULT_MEM_WAIT,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_flush,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_busy,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [127:0]      mem_line
);

  localparam int CNT_W = $clog2(MEM_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT - 1);

  logic [0:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [127:0]            line_q, line_d;
  logic [ADDR_W-1:TAG_LSB] tag_q, tag_d;
  logic                    line_valid_q, line_valid_d;
  logic                    valid_q, valid_d;
  logic [31:0]             instr_q, instr_d;
  logic                    busy_q, busy_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;

  logic        hit;
  logic [31:0] hit_word;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^fetch_addr[WORD_SEL_LSB-1:0];
  assign hit = line_valid_q && (tag_q == fetch_addr[ADDR_W-1:TAG_LSB]);

  line_word_sel u_word_sel (
    .line_i (line_q),
    .sel_i  (fetch_addr[WORD_SEL_MSB:WORD_SEL_LSB]),
    .word_o (hit_word)
  );

  // mem_line is read only on the capture edge so stray X never reaches line_q.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    tag_d        = tag_q;
    line_valid_d = line_valid_q;
    valid_d      = 1'b0;
    instr_d      = instr_q;
    busy_d       = busy_q;
    mem_addr_d   = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (!fetch_flush && fetch_req) begin
          if (hit) begin
            valid_d = 1'b1;
            instr_d = hit_word;
          end else begin
            mem_addr_d   = {fetch_addr[ADDR_W-1:TAG_LSB], {TAG_LSB{1'b0}}};
            line_valid_d = 1'b0;
            cnt_d        = '0;
            busy_d       = 1'b1;
            state_d      = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // A flush wins over a capture landing on the same edge.
        if (fetch_flush) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          line_d       = mem_line;
          tag_d        = mem_addr_q[ADDR_W-1:TAG_LSB];
          line_valid_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      line_q       <= '0;
      tag_q        <= '0;
      line_valid_q <= 1'b0;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      tag_q        <= tag_d;
      line_valid_q <= line_valid_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      busy_q       <= busy_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign fetch_valid = valid_q;
  assign fetch_instr = instr_q;
  assign fetch_busy  = busy_q;
  assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a fixed-latency memory model plus
// a line-buffer reference model driving directed and randomized fetches.
module tb_instr_fetch_unit;

  localparam int MEM_WAIT = 8;
  localparam int MISS_EDGES = MEM_WAIT + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fetch_req = 1'b0;
  logic [31:0]  fetch_addr = '0;
  logic         fetch_flush = 1'b0;
  logic         fetch_valid;
  logic [31:0]  fetch_instr;
  logic         fetch_busy;
  logic [31:0]  mem_addr;
  logic [127:0] memLine = '0;

  int passCount = 0;
  int checkCount = 0;

  // Reference model of the line buffer and the address presented to memory.
  bit          bufValid = 1'b0;
  logic [27:0] bufTag = '0;
  logic [31:0] expMemAddr = '0;

  instr_fetch_unit #(.MEM_WAIT(MEM_WAIT), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_flush (fetch_flush),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_busy  (fetch_busy),
    .mem_addr    (mem_addr),
    .mem_line    (memLine)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    logic [31:0] base;
    logic [31:0] w;
    base = {addr[31:4], 4'b0};
    w = {30'b0, addr[3:2]};
    if (base == 32'h0) return 32'h1111_1111 * (w + 32'd1);
    return (base * 32'h0100_0193) ^ ((w + 32'd1) * 32'h9E37_79B9);
  endfunction

  function automatic logic [127:0] lineData(input logic [31:0] base);
    return {memWord(base), memWord(base + 32'd4), memWord(base + 32'd8), memWord(base + 32'd12)};
  endfunction

  // Memory restarts its count when the line address changes or a new wait
  // begins; valid data is present only for the cycle before the sample edge,
  // random garbage otherwise (stands in for X in a 2-state simulator).
  logic [31:0] prevAddr = '0;
  logic        prevBusy = 1'b0;
  int          memCnt = 0;
  always @(posedge clk) begin
    #2;
    if (mem_addr !== prevAddr || (fetch_busy && !prevBusy)) memCnt = 0;
    else memCnt = memCnt + 1;
    prevAddr = mem_addr;
    prevBusy = fetch_busy;
    if (memCnt == MEM_WAIT - 1) memLine = lineData(mem_addr);
    else memLine = {$urandom(), $urandom(), $urandom(), $urandom()};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds a request until fetch_valid; edge 1 is the edge that first sees it.
  task automatic doFetch(input logic [31:0] addr, output int edges, output int busyCycles,
                         output logic [31:0] instr, output bit timedOut);
    fetch_req = 1'b1;
    fetch_addr = addr;
    edges = 0;
    busyCycles = 0;
    timedOut = 1'b1;
    instr = '0;
    while (timedOut && edges < 40) begin
      tick();
      edges++;
      if (fetch_busy) busyCycles++;
      if (fetch_valid) begin
        timedOut = 1'b0;
        instr = fetch_instr;
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fetch_req = 1'b1;
    fetch_addr = $urandom();
    fetch_flush = 1'b0;
    repeat (2) tick();
    checkCount++;
    if (fetch_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b expected 0", fetch_valid);
    else passCount++;
    checkCount++;
    if (fetch_instr !== 32'h0) $display("[TB] FAIL reset_instr: got %h expected 0", fetch_instr);
    else passCount++;
    checkCount++;
    if (fetch_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b expected 0", fetch_busy);
    else passCount++;
    checkCount++;
    if (mem_addr !== 32'h0) $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr);
    else passCount++;
    fetch_req = 1'b0;
    rst_n = 1'b1;
    bufValid = 1'b0;
    expMemAddr = '0;
    tick();
  endtask

  task automatic test_miss_line0();
    int edges, busyCycles;
    logic [31:0] instr;
    bit timedOut;
    doFetch(32'h0, edges, busyCycles, instr, timedOut);
    checkCount++;
    if (timedOut) $display("[TB] FAIL miss0_timeout: no fetch_valid within 40 edges");
    else passCount++;
    checkCount++;
    if (edges != MISS_EDGES) $display("[TB] FAIL miss0_latency: got %0d expected %0d", edges, MISS_EDGES);
    else passCount++;
    checkCount++;
    if (busyCycles != MEM_WAIT) $display("[TB] FAIL miss0_busy: got %0d expected %0d", busyCycles, MEM_WAIT);
    else passCount++;
    checkCount++;
    if (instr !== 32'h1111_1111) $display("[TB] FAIL miss0_instr: got %h expected 11111111", instr);
    else passCount++;
    checkCount++;
    if (mem_addr !== 32'h0) $display("[TB] FAIL miss0_mem_addr: got %h expected 0", mem_addr);
    else passCount++;
    bufValid = 1'b1;
    bufTag = '0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [4] = '{32'h4, 32'h8, 32'hC, 32'h7};
    fetch_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_addr = seq[i];
      tick();
      checkCount++;
      if (fetch_valid !== 1'b1 || fetch_instr !== memWord(seq[i]))
        $display("[TB] FAIL b2b_%0d: got valid=%0b instr=%h expected valid=1 instr=%h",
                 i, fetch_valid, fetch_instr, memWord(seq[i]));
      else passCount++;
      checkCount++;
      if (mem_addr !== 32'h0) $display("[TB] FAIL b2b_mem_addr_%0d: got %h expected 0", i, mem_addr);
      else passCount++;
    end
    fetch_flush = 1'b1;
    fetch_addr = 32'h0;
    tick();
    checkCount++;
    if (fetch_valid !== 1'b0) $display("[TB] FAIL idle_flush_valid: got %0b expected 0", fetch_valid);
    else passCount++;
    fetch_flush = 1'b0;
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    int edges, busyCycles;
    logic [31:0] instr;
    bit timedOut;
    fetch_req = 1'b1;
    fetch_addr = 32'h10;
    tick();
    checkCount++;
    if (fetch_busy !== 1'b1 || mem_addr !== 32'h10)
      $display("[TB] FAIL flush_enter: got busy=%0b mem_addr=%h expected busy=1 mem_addr=10", fetch_busy, mem_addr);
    else passCount++;
    repeat (3) tick();
    fetch_flush = 1'b1;
    fetch_addr = 32'h40;
    tick();
    checkCount++;
    if (fetch_busy !== 1'b0 || fetch_valid !== 1'b0 || mem_addr !== 32'h10)
      $display("[TB] FAIL flush_edge: got busy=%0b valid=%0b mem_addr=%h expected 0 0 10",
               fetch_busy, fetch_valid, mem_addr);
    else passCount++;
    fetch_flush = 1'b0;
    doFetch(32'h40, edges, busyCycles, instr, timedOut);
    checkCount++;
    if (timedOut || edges != MISS_EDGES || instr !== memWord(32'h40) || mem_addr !== 32'h40)
      $display("[TB] FAIL flush_refetch: got edges=%0d instr=%h mem_addr=%h expected edges=%0d instr=%h mem_addr=40",
               edges, instr, mem_addr, MISS_EDGES, memWord(32'h40));
    else passCount++;
    // Flush landing on the capture edge must leave the line unbuffered.
    fetch_req = 1'b1;
    fetch_addr = 32'h50;
    repeat (MEM_WAIT) tick();
    fetch_flush = 1'b1;
    tick();
    fetch_flush = 1'b0;
    fetch_req = 1'b0;
    tick();
    doFetch(32'h54, edges, busyCycles, instr, timedOut);
    checkCount++;
    if (timedOut || edges != MISS_EDGES || instr !== memWord(32'h54))
      $display("[TB] FAIL flush_vs_capture: got edges=%0d instr=%h expected edges=%0d instr=%h",
               edges, instr, MISS_EDGES, memWord(32'h54));
    else passCount++;
  endtask

  task automatic test_reset_midwait();
    int edges, busyCycles;
    logic [31:0] instr;
    bit timedOut;
    fetch_req = 1'b1;
    fetch_addr = 32'h20;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    checkCount++;
    if (fetch_valid !== 1'b0 || fetch_busy !== 1'b0 || mem_addr !== 32'h0 || fetch_instr !== 32'h0)
      $display("[TB] FAIL midwait_reset: got valid=%0b busy=%0b mem_addr=%h instr=%h expected all zero",
               fetch_valid, fetch_busy, mem_addr, fetch_instr);
    else passCount++;
    rst_n = 1'b1;
    fetch_req = 1'b0;
    tick();
    doFetch(32'h58, edges, busyCycles, instr, timedOut);
    checkCount++;
    if (timedOut || edges != MISS_EDGES || instr !== memWord(32'h58))
      $display("[TB] FAIL midwait_remiss: got edges=%0d instr=%h expected edges=%0d instr=%h",
               edges, instr, MISS_EDGES, memWord(32'h58));
    else passCount++;
    bufValid = 1'b1;
    bufTag = 28'h5;
    expMemAddr = 32'h50;
  endtask

  task automatic test_random();
    int edges, busyCycles, expEdges, expBusy;
    logic [31:0] instr, addr;
    bit timedOut, hit;
    for (int n = 0; n < 40; n++) begin
      addr = 32'($urandom_range(0, 63)) + ((n % 8 == 0) ? 32'h1000 : 32'h0);
      hit = bufValid && (bufTag == addr[31:4]);
      expEdges = hit ? 1 : MISS_EDGES;
      expBusy = hit ? 0 : MEM_WAIT;
      if (!hit) begin
        bufValid = 1'b1;
        bufTag = addr[31:4];
        expMemAddr = {addr[31:4], 4'b0};
      end
      doFetch(addr, edges, busyCycles, instr, timedOut);
      checkCount++;
      if (timedOut || edges != expEdges || busyCycles != expBusy)
        $display("[TB] FAIL rand_timing_%0d: addr=%h got edges=%0d busy=%0d expected edges=%0d busy=%0d",
                 n, addr, edges, busyCycles, expEdges, expBusy);
      else passCount++;
      checkCount++;
      if (instr !== memWord(addr) || mem_addr !== expMemAddr)
        $display("[TB] FAIL rand_data_%0d: addr=%h got instr=%h mem_addr=%h expected instr=%h mem_addr=%h",
                 n, addr, instr, mem_addr, memWord(addr), expMemAddr);
      else passCount++;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_miss_line0();
    test_back_to_back();
    test_flush();
    test_reset_midwait();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
